// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares the register-file write port between pipeline WB and a 1-entry MUL/DIV result buffer, with a pending-destination scoreboard; optional forwarding from the buffer under RF_ARB_BYPASS_EN
module regfile_wb_arbiter #(
  parameter int REG_WIDTH = 32,
  parameter int REG_COUNT = 32,
  parameter int STARVE_LIMIT = 4,
  localparam int AW = $clog2(REG_COUNT)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 issue_valid,
  input  logic                 issue_md,
  input  logic [AW-1:0]        issue_rd,
  input  logic [AW-1:0]        rs1,
  input  logic [AW-1:0]        rs2,
  output logic                 issue_stall,
  input  logic                 wb_valid,
  input  logic [AW-1:0]        wb_rd,
  input  logic [REG_WIDTH-1:0] wb_data,
  output logic                 wb_stall,
  input  logic                 md_valid,
  input  logic [AW-1:0]        md_rd,
  input  logic [REG_WIDTH-1:0] md_data,
  output logic                 md_ready,
  output logic                 RegWrite,
  output logic [AW-1:0]        rd,
  output logic [REG_WIDTH-1:0] BusW
`ifdef RF_ARB_BYPASS_EN
  ,
  output logic                 fwd_a_hit,
  output logic                 fwd_b_hit,
  output logic [REG_WIDTH-1:0] fwd_a,
  output logic [REG_WIDTH-1:0] fwd_b
`endif
);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  logic                 r_buf_full;
  logic [AW-1:0]        r_buf_rd;
  logic [REG_WIDTH-1:0] r_buf_data;
  logic [REG_COUNT-1:0] r_pending;
  logic [SW-1:0]        r_starve_cnt;
  logic                 w_force;
  logic                 w_md_grant;
  logic                 w_wb_grant;
  logic                 w_accept;
  logic                 w_hit_a;
  logic                 w_hit_b;
  logic [REG_COUNT-1:0] w_set;
  logic [REG_COUNT-1:0] w_clr;
  logic [SW-1:0]        w_starve_nxt;

  // Arbitration, write-port drive and stall generation
  always_comb begin
    w_force      = r_buf_full && (r_starve_cnt >= SW'(STARVE_LIMIT));
    w_md_grant   = r_buf_full && (w_force || !wb_valid);
    w_wb_grant   = wb_valid && !w_force;
    wb_stall     = w_force && wb_valid;
    md_ready     = !r_buf_full || w_md_grant;
    w_accept     = md_valid && md_ready;
    RegWrite     = w_md_grant ? (r_buf_rd != '0) : (w_wb_grant && wb_rd != '0);
    rd           = w_md_grant ? r_buf_rd : (w_wb_grant ? wb_rd : '0);
    BusW         = w_md_grant ? r_buf_data : (w_wb_grant ? wb_data : '0);
    w_starve_nxt = (!r_buf_full || w_md_grant) ? '0 :
                   (r_starve_cnt < SW'(STARVE_LIMIT) ? r_starve_cnt + SW'(1) : r_starve_cnt);
`ifdef RF_ARB_BYPASS_EN
    w_hit_a      = r_buf_full && r_buf_rd == rs1 && rs1 != '0;
    w_hit_b      = r_buf_full && r_buf_rd == rs2 && rs2 != '0;
    fwd_a_hit    = w_hit_a;
    fwd_b_hit    = w_hit_b;
    fwd_a        = w_hit_a ? r_buf_data : '0;
    fwd_b        = w_hit_b ? r_buf_data : '0;
`else
    w_hit_a      = 1'b0;
    w_hit_b      = 1'b0;
`endif
    issue_stall  = issue_valid && ((r_pending[rs1] && !w_hit_a) || (r_pending[rs2] && !w_hit_b) ||
                                   r_pending[issue_rd]);
    w_set        = '0;
    w_clr        = '0;
    w_set[issue_rd] = issue_valid && issue_md && !issue_stall && issue_rd != '0;
    w_clr[r_buf_rd] = w_md_grant;
  end

  // Buffer, starvation counter and scoreboard state; a same-cycle set beats a clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_buf_full   <= 1'b0;
      r_buf_rd     <= '0;
      r_buf_data   <= '0;
      r_pending    <= '0;
      r_starve_cnt <= '0;
    end else begin
      r_buf_full   <= w_accept || (r_buf_full && !w_md_grant);
      r_buf_rd     <= w_accept ? md_rd : r_buf_rd;
      r_buf_data   <= w_accept ? md_data : r_buf_data;
      r_pending    <= ((r_pending & ~w_clr) | w_set) & ~REG_COUNT'(1);
      r_starve_cnt <= w_starve_nxt;
    end
  end

  a_md_rd_pending: assert property (@(posedge clk) disable iff (reset)
    (md_valid && md_ready) |-> r_pending[md_rd])
    else $error("md result for a destination that is not pending");
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed self-checking bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        issue_valid = 1'b0, issue_md = 1'b0;
  logic [4:0]  issue_rd = '0, rs1 = '0, rs2 = '0;
  logic        issue_stall;
  logic        wb_valid = 1'b0;
  logic [4:0]  wb_rd = '0;
  logic [31:0] wb_data = '0;
  logic        wb_stall;
  logic        md_valid = 1'b0;
  logic [4:0]  md_rd = '0;
  logic [31:0] md_data = '0;
  logic        md_ready;
  logic        RegWrite;
  logic [4:0]  rd;
  logic [31:0] BusW;
`ifdef RF_ARB_BYPASS_EN
  logic        fwd_a_hit, fwd_b_hit;
  logic [31:0] fwd_a, fwd_b;
`endif
  int checks = 0;
  int errors = 0;

  regfile_wb_arbiter #(.REG_WIDTH(32), .REG_COUNT(32), .STARVE_LIMIT(4)) dut (
    .clk(clk), .reset(reset),
    .issue_valid(issue_valid), .issue_md(issue_md), .issue_rd(issue_rd),
    .rs1(rs1), .rs2(rs2), .issue_stall(issue_stall),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .wb_stall(wb_stall),
    .md_valid(md_valid), .md_rd(md_rd), .md_data(md_data), .md_ready(md_ready),
    .RegWrite(RegWrite), .rd(rd), .BusW(BusW)
`ifdef RF_ARB_BYPASS_EN
    , .fwd_a_hit(fwd_a_hit), .fwd_b_hit(fwd_b_hit), .fwd_a(fwd_a), .fwd_b(fwd_b)
`endif
  );

  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    issue_valid = 1'b0; issue_md = 1'b0; issue_rd = '0; rs1 = '0; rs2 = '0;
    wb_valid = 1'b0; wb_rd = '0; wb_data = '0;
    md_valid = 1'b0; md_rd = '0; md_data = '0;
  endtask

  task automatic issue(input logic [4:0] d);
    step();
    idle_inputs();
    issue_valid = 1'b1; issue_md = 1'b1; issue_rd = d;
    #1;
    checks++;
    if (issue_stall !== 1'b0) begin errors++; $display("FAIL issue_md_%0d issue_stall=%b want 0", d, issue_stall); end
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    repeat (2) step();
    reset = 1'b0;
    issue_valid = 1'b1; issue_rd = 5'd9; rs1 = 5'd5; rs2 = 5'd7;
    #1;
    checks++;
    if (RegWrite !== 1'b0 || rd !== 5'd0 || BusW !== 32'd0) begin errors++; $display("FAIL reset_write RegWrite=%b rd=%0d BusW=%h want 0/0/0", RegWrite, rd, BusW); end
    checks++;
    if (md_ready !== 1'b1 || wb_stall !== 1'b0) begin errors++; $display("FAIL reset_ready md_ready=%b wb_stall=%b want 1/0", md_ready, wb_stall); end
    checks++;
    if (issue_stall !== 1'b0) begin errors++; $display("FAIL reset_stall issue_stall=%b want 0", issue_stall); end
  endtask

  task automatic test_md_hazard();
    issue(5'd5);
    step();
    idle_inputs();
    issue_valid = 1'b1; issue_rd = 5'd3; rs1 = 5'd5;
    #1;
    checks++;
    if (issue_stall !== 1'b1) begin errors++; $display("FAIL raw_stall issue_stall=%b want 1", issue_stall); end
    step();
    idle_inputs();
    md_valid = 1'b1; md_rd = 5'd5; md_data = 32'h1234;
    #1;
    checks++;
    if (md_ready !== 1'b1 || RegWrite !== 1'b0) begin errors++; $display("FAIL md_accept md_ready=%b RegWrite=%b want 1/0", md_ready, RegWrite); end
    step();
    idle_inputs();
    issue_valid = 1'b1; issue_rd = 5'd3; rs1 = 5'd5;
    #1;
    checks++;
    if (RegWrite !== 1'b1 || rd !== 5'd5 || BusW !== 32'h1234) begin errors++; $display("FAIL md_write RegWrite=%b rd=%0d BusW=%h want 1/5/00001234", RegWrite, rd, BusW); end
    checks++;
    if (issue_stall !== 1'b1) begin errors++; $display("FAIL stall_during_grant issue_stall=%b want 1", issue_stall); end
    step();
    #1;
    checks++;
    if (issue_stall !== 1'b0 || RegWrite !== 1'b0) begin errors++; $display("FAIL stall_release issue_stall=%b RegWrite=%b want 0/0", issue_stall, RegWrite); end
  endtask

  task automatic test_starvation();
    issue(5'd7);
    step();
    idle_inputs();
    md_valid = 1'b1; md_rd = 5'd7; md_data = 32'h77;
    for (int i = 0; i < 6; i++) begin
      step();
      idle_inputs();
      wb_valid = 1'b1; wb_rd = 5'd3; wb_data = 32'hAA;
      #1;
      checks++;
      if (i == 4) begin
        if (RegWrite !== 1'b1 || rd !== 5'd7 || BusW !== 32'h77 || wb_stall !== 1'b1) begin
          errors++; $display("FAIL starve_force cyc=%0d RegWrite=%b rd=%0d BusW=%h wb_stall=%b want 1/7/00000077/1", i, RegWrite, rd, BusW, wb_stall);
        end
      end else if (RegWrite !== 1'b1 || rd !== 5'd3 || BusW !== 32'hAA || wb_stall !== 1'b0) begin
        errors++; $display("FAIL starve_wb cyc=%0d RegWrite=%b rd=%0d BusW=%h wb_stall=%b want 1/3/000000aa/0", i, RegWrite, rd, BusW, wb_stall);
      end
    end
    step();
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    issue(5'd10);
    issue(5'd11);
    step();
    idle_inputs();
    md_valid = 1'b1; md_rd = 5'd10; md_data = 32'hA0;
    wb_valid = 1'b1; wb_rd = 5'd2; wb_data = 32'h22;
    step();
    md_rd = 5'd11; md_data = 32'hB0;
    #1;
    checks++;
    if (md_ready !== 1'b0 || rd !== 5'd2 || BusW !== 32'h22) begin errors++; $display("FAIL full_backpressure md_ready=%b rd=%0d BusW=%h want 0/2/00000022", md_ready, rd, BusW); end
    step();
    wb_valid = 1'b0;
    #1;
    checks++;
    if (md_ready !== 1'b1 || RegWrite !== 1'b1 || rd !== 5'd10 || BusW !== 32'hA0) begin
      errors++; $display("FAIL b2b_first md_ready=%b RegWrite=%b rd=%0d BusW=%h want 1/1/10/000000a0", md_ready, RegWrite, rd, BusW);
    end
    step();
    idle_inputs();
    #1;
    checks++;
    if (RegWrite !== 1'b1 || rd !== 5'd11 || BusW !== 32'hB0) begin errors++; $display("FAIL b2b_second RegWrite=%b rd=%0d BusW=%h want 1/11/000000b0", RegWrite, rd, BusW); end
    step();
    #1;
    checks++;
    if (RegWrite !== 1'b0) begin errors++; $display("FAIL b2b_idle RegWrite=%b want 0", RegWrite); end
  endtask

  task automatic test_x0();
    issue(5'd0);
    step();
    idle_inputs();
    issue_valid = 1'b1; issue_rd = 5'd0; rs1 = 5'd0; rs2 = 5'd0;
    wb_valid = 1'b1; wb_rd = 5'd0; wb_data = 32'hFFFF;
    #1;
    checks++;
    if (issue_stall !== 1'b0) begin errors++; $display("FAIL x0_pending issue_stall=%b want 0", issue_stall); end
    checks++;
    if (RegWrite !== 1'b0) begin errors++; $display("FAIL x0_write RegWrite=%b want 0", RegWrite); end
  endtask

  task automatic test_reset_mid();
    issue(5'd9);
    step();
    idle_inputs();
    md_valid = 1'b1; md_rd = 5'd9; md_data = 32'h99;
    wb_valid = 1'b1; wb_rd = 5'd4; wb_data = 32'h44;
    step();
    md_valid = 1'b0;
    issue_valid = 1'b1; issue_rd = 5'd12; rs1 = 5'd1; rs2 = 5'd9;
    #1;
    checks++;
    if (md_ready !== 1'b0) begin errors++; $display("FAIL pre_reset_full md_ready=%b want 0", md_ready); end
`ifdef RF_ARB_BYPASS_EN
    checks++;
    if (fwd_b_hit !== 1'b1 || fwd_b !== 32'h99 || fwd_a_hit !== 1'b0 || issue_stall !== 1'b0) begin
      errors++; $display("FAIL bypass_b fwd_b_hit=%b fwd_b=%h fwd_a_hit=%b issue_stall=%b want 1/00000099/0/0", fwd_b_hit, fwd_b, fwd_a_hit, issue_stall);
    end
`else
    checks++;
    if (issue_stall !== 1'b1) begin errors++; $display("FAIL pending_rs2 issue_stall=%b want 1", issue_stall); end
`endif
    wb_valid = 1'b0;
    reset = 1'b1;
    #1;
    checks++;
    if (RegWrite !== 1'b0 || md_ready !== 1'b1) begin errors++; $display("FAIL reset_async RegWrite=%b md_ready=%b want 0/1", RegWrite, md_ready); end
    step();
    reset = 1'b0;
    step();
    idle_inputs();
    issue_valid = 1'b1; issue_rd = 5'd9; rs1 = 5'd9; rs2 = 5'd9;
    #1;
    checks++;
    if (issue_stall !== 1'b0 || RegWrite !== 1'b0 || md_ready !== 1'b1) begin
      errors++; $display("FAIL reset_clear issue_stall=%b RegWrite=%b md_ready=%b want 0/0/1", issue_stall, RegWrite, md_ready);
    end
  endtask

  initial begin
    test_reset();
    test_md_hazard();
    test_starvation();
    test_back_to_back();
    test_x0();
    test_reset_mid();
    step();
    idle_inputs();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
